// File: rtl/rpn_tokenizer.sv
// ASCII byte stream to RPN token stream (unsigned decimal numbers, operators, newline terminator).
// Define RPN_TOKENIZER_SAT_EN to saturate oversized numbers at all-ones instead of wrapping.
module rpn_tokenizer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             input_stb,
    input  logic [7:0]       input_data,
    output logic             input_ack,
    output logic             output_stb,
    output logic [WIDTH-1:0] output_data,
    output logic             is_output_operator,
    input  logic             output_ack,
    output logic             error,
    output logic [1:0]       state_dbg
);

    // Handshake: a byte moves on a rising edge with input_stb && input_ack; a token
    // moves on a rising edge with output_stb && output_ack. While output_stb is high
    // and output_ack is low, output_data and is_output_operator do not change.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        NUM      = 2'd1,
        EMIT_NUM = 2'd2,
        EMIT_OP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [7:0]       op_code;
    logic             op_pending;

    logic             is_digit;
    logic             is_delim;
    logic             is_space;
    logic [WIDTH+3:0] acc_prod;
    logic [WIDTH-1:0] acc_mac;

    always_comb begin
        is_digit = (input_data >= 8'h30) && (input_data <= 8'h39);
        is_space = (input_data == 8'h20);
        is_delim = 1'b0;
        case (input_data)
            8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h28, 8'h29, 8'h0A: is_delim = 1'b1;
            default: is_delim = 1'b0;
        endcase
    end

    // acc*10 + digit computed with 4 spare bits so overflow is visible.
    always_comb begin
        acc_prod = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                 + {{WIDTH{1'b0}}, input_data[3:0]};
`ifdef RPN_TOKENIZER_SAT_EN
        acc_mac = (|acc_prod[WIDTH+3:WIDTH]) ? {WIDTH{1'b1}} : acc_prod[WIDTH-1:0];
`else
        acc_mac = acc_prod[WIDTH-1:0];
`endif
    end

    assign input_ack = (state == IDLE) || (state == NUM);
    assign state_dbg = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state              <= IDLE;
            acc                <= '0;
            op_code            <= '0;
            op_pending         <= 1'b0;
            output_stb         <= 1'b0;
            output_data        <= '0;
            is_output_operator <= 1'b0;
            error              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_stb) begin
                        if (is_digit) begin
                            acc   <= {{(WIDTH-4){1'b0}}, input_data[3:0]};
                            state <= NUM;
                        end else if (is_delim) begin
                            output_data        <= {{(WIDTH-8){1'b0}}, input_data};
                            is_output_operator <= 1'b1;
                            output_stb         <= 1'b1;
                            state              <= EMIT_OP;
                        end else if (!is_space) begin
                            error <= 1'b1;
                        end
                    end
                end
                NUM: begin
                    if (input_stb) begin
                        if (is_digit) begin
                            acc <= acc_mac;
                        end else if (is_space || is_delim) begin
                            op_code            <= input_data;
                            op_pending         <= is_delim;
                            output_data        <= acc;
                            is_output_operator <= 1'b0;
                            output_stb         <= 1'b1;
                            state              <= EMIT_NUM;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                EMIT_NUM: begin
                    if (output_ack) begin
                        acc <= '0;
                        if (op_pending) begin
                            output_data        <= {{(WIDTH-8){1'b0}}, op_code};
                            is_output_operator <= 1'b1;
                            op_pending         <= 1'b0;
                            state              <= EMIT_OP;
                        end else begin
                            output_stb <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                EMIT_OP: begin
                    if (output_ack) begin
                        output_stb <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_tokenizer.sv
// Directed bench for rpn_tokenizer: feeds ASCII strings and compares the token stream.
module tb_rpn_tokenizer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         input_stb;
  logic [7:0]   input_data;
  logic         input_ack;
  logic         output_stb;
  logic [W-1:0] output_data;
  logic         is_output_operator;
  logic         output_ack;
  logic         error;
  logic [1:0]   state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  logic [W:0] obs_q[$];
  logic [W:0] exp_q[$];
  bit         send_done;

  always #5 clk = ~clk;

  rpn_tokenizer #(.WIDTH(W)) dut (
    .CLK                (clk),
    .RST                (rst),
    .input_stb          (input_stb),
    .input_data         (input_data),
    .input_ack          (input_ack),
    .output_stb         (output_stb),
    .output_data        (output_data),
    .is_output_operator (is_output_operator),
    .output_ack         (output_ack),
    .error              (error),
    .state_dbg          (state_dbg)
  );

  // Token monitor: records every completed output transfer as {flag, data}.
  always @(posedge clk) begin
    if (!rst && output_stb && output_ack)
      obs_q.push_back({is_output_operator, output_data});
  end

  task automatic send_str(input string s);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      input_stb  = 1'b1;
      input_data = s[i];
      n = 0;
      while (!input_ack && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!input_ack) begin
        n_total++;
        $display("FAIL send_timeout byte %0d of \"%s\": input_ack=%b, required 1", i, s, input_ack);
        input_stb = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    input_stb = 1'b0;
  endtask

  // Waits (bounded) until n tokens have been seen, then lets the pipe settle.
  task automatic wait_tokens(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; input_stb = 1'b0; input_data = 8'h00; output_ack = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({input_ack, output_stb, output_data, is_output_operator, error, state_dbg} !==
        {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL reset_values ack=%b stb=%b data=%h op=%b err=%b st=%0d, required 1 0 0 0 0 0",
               input_ack, output_stb, output_data, is_output_operator, error, state_dbg);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'd12}); exp_q.push_back({1'b1, 32'h2B});
    exp_q.push_back({1'b0, 32'd3});  exp_q.push_back({1'b1, 32'h0A});
    send_str("12+3\n");
    wait_tokens(exp_q.size());
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL basic_count got %0d tokens, required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic_tok%0d got %h, required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (error !== 1'b0) $display("FAIL basic_error got %b, required 0", error);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int k;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'd45}); exp_q.push_back({1'b0, 32'd6});
    exp_q.push_back({1'b1, 32'h2A});
    output_ack = 1'b0;
    send_done = 1'b0;
    fork
      begin
        send_str("  45 6*");
        send_done = 1'b1;
      end
    join_none
    k = 0;
    while (!output_stb && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({output_stb, output_data, is_output_operator, input_ack} !== {1'b1, 32'd45, 1'b0, 1'b0})
        $display("FAIL hold_cyc%0d stb=%b data=%0d op=%b in_ack=%b, required 1 45 0 0",
                 c, output_stb, output_data, is_output_operator, input_ack);
      else n_pass++;
      @(negedge clk);
    end
    output_ack = 1'b1;
    wait_tokens(exp_q.size());
    k = 0;
    while (!send_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL bp_count got %0d tokens, required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bp_tok%0d got %h, required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'd99});
    send_str("9a9 ");
    wait_tokens(exp_q.size());
    n_total++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL illegal_tok got %0d tokens first=%h, required 1 token %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    else n_pass++;
    n_total++;
    if (error !== 1'b1) $display("FAIL illegal_error got %b, required 1", error);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (error !== 1'b1) $display("FAIL error_sticky got %b, required 1", error);
    else n_pass++;
  endtask

  task automatic test_overflow;
    obs_q.delete(); exp_q.delete();
`ifdef RPN_TOKENIZER_SAT_EN
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
`else
    exp_q.push_back({1'b0, 32'h0000_0000});
`endif
    send_str("4294967296 ");
    wait_tokens(exp_q.size());
    n_total++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL overflow_tok got %0d tokens first=%h, required 1 token %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_parens;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b1, 32'h28}); exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b1, 32'h2D}); exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b1, 32'h29}); exp_q.push_back({1'b1, 32'h2F});
    exp_q.push_back({1'b0, 32'd3});  exp_q.push_back({1'b1, 32'h0A});
    send_str("(1-2)/3\n");
    wait_tokens(exp_q.size());
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL parens_count got %0d tokens, required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL parens_tok%0d got %h, required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'd5});
    send_str("78");
    rst = 1'b1;
    #1;
    n_total++;
    if ({input_ack, output_stb, output_data, is_output_operator, error, state_dbg} !==
        {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 2'd0})
      $display("FAIL mid_reset_values ack=%b stb=%b data=%h op=%b err=%b st=%0d, required 1 0 0 0 0 0",
               input_ack, output_stb, output_data, is_output_operator, error, state_dbg);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_str("5 ");
    wait_tokens(exp_q.size());
    n_total++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL mid_reset_tok got %0d tokens first=%h, required 1 token %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    else n_pass++;
    n_total++;
    if (error !== 1'b0) $display("FAIL mid_reset_error got %b, required 0", error);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_illegal;
    test_overflow;
    test_parens;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time budget, required completion");
    $fatal(1, "timeout");
  end

endmodule
